lsu_stage: RTL and testbench

- Load/store unit between exe_stage and rd_wmux in the RV64 core.
- Takes the ALU-computed address and the load/store controls from id_stage, then runs a multi-cycle req/ack transaction on the data bus.
- Aligns store data and mask. Extracts and sign/zero-extends load data.
- Stalls the core until the access completes, times out, or is rejected as misaligned.

---
 rtl/lsu_stage_pkg.sv | 40 ++++
 rtl/lsu_stage_load_ext.sv | 27 ++
 rtl/lsu_stage.sv | 144 ++++++++++++++
 tb/tb_lsu_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store unit: access size masks, FSM states,
// default bus timeout and small mask helpers.
package lsu_stage_pkg;

  localparam logic [7:0] SZ_B = 8'h01;
  localparam logic [7:0] SZ_H = 8'h03;
  localparam logic [7:0] SZ_W = 8'h0F;
  localparam logic [7:0] SZ_D = 8'hFF;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Low address bits that must be zero for a naturally aligned access (size-1).
  function automatic logic [2:0] align_mask(input logic [7:0] be);
    logic [2:0] m;
    case (be)
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      SZ_D:    m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Expand a byte mask to a bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_stage_load_ext.sv
// Load data extraction: shift the aligned doubleword down to the accessed
// bytes, then sign- or zero-extend according to the access size.
module lsu_load_ext
  import lsu_stage_pkg::*;
(
  input  logic [63:0] bus_rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [7:0]  byte_enable_i,
  input  logic        mem_ext_un_i,
  output logic [63:0] data_o
);

  logic [63:0] raw;

  // Shift, mask to size and extend from the size's top bit.
  always_comb begin
    raw    = bus_rdata_i >> {offset_i, 3'b000};
    data_o = raw;
    case (byte_enable_i)
      SZ_B:    data_o = {{56{~mem_ext_un_i & raw[7]}},  raw[7:0]};
      SZ_H:    data_o = {{48{~mem_ext_un_i & raw[15]}}, raw[15:0]};
      SZ_W:    data_o = {{32{~mem_ext_un_i & raw[31]}}, raw[31:0]};
      default: data_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store unit: captures one access from the core, runs a req/ack bus
// transaction with a timeout, and returns extended load data with a one-cycle
// done pulse. Misaligned accesses complete immediately with an error.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_ena,
  input  logic        mem_w_ena,
  input  logic [7:0]  byte_enable,
  input  logic        mem_ext_un,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [63:0] bus_wmask,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  offset_q;
  logic [7:0]  be_q;
  logic        ext_un_q;
  logic        done_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [63:0] bus_addr_q;
  logic [63:0] bus_wdata_q;
  logic [63:0] bus_wmask_q;

  logic        req_any;
  logic        misaligned;
  logic [7:0]  be_shift;
  logic [63:0] load_data;

  // Request decode, alignment check and shifted byte mask for the incoming access.
  always_comb begin
    req_any    = mem_r_ena | mem_w_ena;
    misaligned = (addr[2:0] & align_mask(byte_enable)) != 3'b000;
    be_shift   = byte_enable << addr[2:0];
    stall      = ((state_q == ST_IDLE) & req_any) | (state_q == ST_REQ);
  end

  lsu_load_ext u_load_ext (
    .bus_rdata_i   (bus_rdata),
    .offset_i      (offset_q),
    .byte_enable_i (be_q),
    .mem_ext_un_i  (ext_un_q),
    .data_o        (load_data)
  );

  // Transaction FSM with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      offset_q    <= '0;
      be_q        <= '0;
      ext_un_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            offset_q <= addr[2:0];
            be_q     <= byte_enable;
            ext_un_q <= mem_ext_un;
            if (misaligned) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= ST_REQ;
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_w_ena;
              bus_addr_q  <= {addr[63:3], 3'b000};
              bus_wdata_q <= wdata << {addr[2:0], 3'b000};
              bus_wmask_q <= expand_mask(be_shift);
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          // An ack in the timeout cycle still completes the access cleanly.
          if (bus_ack) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            if (!bus_we_q) begin
              rdata_q <= load_data;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign lsu_err   = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wmask = bus_wmask_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: directed cases plus randomized accesses,
// checked against a byte-level reference model of the load/store rules.
module tb_lsu_stage;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_ena = 1'b0;
  logic        mem_w_ena = 1'b0;
  logic [7:0]  byte_enable = '0;
  logic        mem_ext_un = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        stall, done, lsu_err, bus_req, bus_we;
  logic [63:0] rdata, bus_addr, bus_wdata, bus_wmask;
  logic        bus_ack = 1'b0;
  logic [63:0] bus_rdata = '0;

  always #5 clk = ~clk;

  lsu_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_r_ena(mem_r_ena), .mem_w_ena(mem_w_ena),
    .byte_enable(byte_enable), .mem_ext_un(mem_ext_un), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct { logic [63:0] rd; logic err; } sb_t;
  typedef struct {
    logic [63:0] addr, wdata, wmask, rdata;
    logic        we;
    int          ack_cyc;
  } bus_t;

  sb_t         sbq[$];
  bus_t        bq[$];
  int          tests = 0;
  int          fails = 0;
  logic [63:0] mdl_rdata = '0;
  bit          abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int exp_len(input int ack_cyc);
    return (ack_cyc >= 1 && ack_cyc <= int'(TO)) ? ack_cyc : int'(TO);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] d, input int off,
                                           input int nb, input bit un);
    logic [63:0] v;
    logic [63:0] m;
    v = d >> (8 * off);
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!un && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [7:0] be_of(input int nb);
    case (nb)
      1:       return 8'h01;
      2:       return 8'h03;
      4:       return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Compute the expected outcome, queue it, and present the request to the DUT.
  task automatic issue(input bit r, input bit w, input logic [7:0] be, input bit un,
                       input logic [63:0] a, input logic [63:0] wd, input int ack_cyc,
                       input logic [63:0] brd, output int exp_done);
    int   nb;
    int   off;
    bus_t b;
    sb_t  s;
    nb  = $countones(be);
    off = int'(a[2:0]);
    if ((off % nb) != 0) begin
      s.err    = 1'b1;
      s.rd     = mdl_rdata;
      exp_done = 2;
    end else begin
      b.addr    = a & ~64'h7;
      b.we      = w;
      b.wdata   = wd << (8 * off);
      b.wmask   = '0;
      for (int i = 0; i < 8; i++)
        if (i >= off && i < off + nb) b.wmask = b.wmask | (64'hFF << (8 * i));
      b.rdata   = brd;
      b.ack_cyc = ack_cyc;
      bq.push_back(b);
      exp_done = exp_len(ack_cyc) + 2;
      if (ack_cyc >= 1 && ack_cyc <= int'(TO)) begin
        s.err = 1'b0;
        s.rd  = w ? mdl_rdata : ref_load(brd, off, nb, un);
      end else begin
        s.err = 1'b1;
        s.rd  = '0;
      end
    end
    mdl_rdata = s.rd;
    sbq.push_back(s);
    @(negedge clk);
    mem_r_ena = r; mem_w_ena = w; byte_enable = be; mem_ext_un = un;
    addr = a; wdata = wd;
  endtask

  // Count stall cycles and find the done cycle (request cycle is 1), then release.
  task automatic wait_done(output int done_cyc, output int stall_cnt);
    int cyc;
    done_cyc  = 0;
    stall_cnt = 0;
    #1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (stall) stall_cnt++;
      @(negedge clk);
      #1;
    end
    if (done_cyc == 0) begin
      tests++; fails++;
      $display("FAIL done_wait: got no done within 60 cycles required done");
    end
    mem_r_ena = 1'b0;
    mem_w_ena = 1'b0;
  endtask

  task automatic run(input string name, input bit r, input bit w, input logic [7:0] be,
                     input bit un, input logic [63:0] a, input logic [63:0] wd,
                     input int ack_cyc, input logic [63:0] brd);
    int exp_done, done_cyc, stall_cnt;
    issue(r, w, be, un, a, wd, ack_cyc, brd, exp_done);
    wait_done(done_cyc, stall_cnt);
    chk({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_done - 1));
  endtask

  // Bus model: checks stable request fields every REQ cycle and acks on the chosen cycle.
  initial begin : responder
    bus_t cur;
    bit   in_txn;
    bit   have;
    int   len;
    in_txn = 1'b0; have = 1'b0; len = 0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          len    = 0;
          if (bq.size() == 0) begin
            tests++; fails++; have = 1'b0;
            $display("FAIL unexpected_bus_req: got bus_req=1 required 0");
          end else begin
            cur  = bq.pop_front();
            have = 1'b1;
          end
        end
        len++;
        if (have) begin
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_we", 64'(bus_we), 64'(cur.we));
          chk("bus_wdata", bus_wdata, cur.wdata);
          chk("bus_wmask", bus_wmask, cur.wmask);
          if (cur.ack_cyc == len) begin
            bus_ack = 1'b1; bus_rdata = cur.rdata;
          end else begin
            bus_ack = 1'b0; bus_rdata = {$urandom, $urandom};
          end
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        bus_ack = 1'b0;
        if (in_txn) begin
          in_txn = 1'b0;
          if (have && !abort) chk("bus_req_len", 64'(len), 64'(exp_len(cur.ack_cyc)));
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 required 0");
        end else begin
          e = sbq.pop_front();
          chk("rdata", rdata, e.rd);
          chk("lsu_err", 64'(lsu_err), 64'(e.err));
        end
      end
    end
  end

  initial begin : stim
    int          exp_done;
    int          nb, kind, ack;
    bit          r, w;
    logic [63:0] a;

    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_err", 64'(lsu_err), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_we", 64'(bus_we), 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    chk("rst_bus_wmask", bus_wmask, 64'd0);
    rst = 1'b0;

    run("lb_sext", 1, 0, 8'h01, 0, 64'h8000_1003, 64'h0, 1, 64'h0000_0000_8000_0000);
    run("sh", 0, 1, 8'h03, 0, 64'h8000_2006, 64'hBEEF, 1, 64'h0);
    run("lwu_delay", 1, 0, 8'h0F, 1, 64'h8000_0004, 64'h0, 5, 64'hF000_0000_1234_5678);
    run("ld_misaligned", 1, 0, 8'hFF, 0, 64'h8000_0004, 64'h0, 1, 64'h0);
    run("ld_timeout", 1, 0, 8'hFF, 0, 64'h8000_0010, 64'h0, 0, 64'h1);
    run("ld_ack_at_timeout", 1, 0, 8'hFF, 0, 64'h8000_0010, 64'h0, int'(TO), 64'h1122_3344_5566_7788);
    run("both_ena_write", 1, 1, 8'h0F, 0, 64'h8000_0020, 64'hCAFE_F00D, 2, 64'h0);

    // Reset while the bus request is outstanding.
    issue(1, 0, 8'hFF, 0, 64'h8000_0040, 64'h0, 0, 64'h0, exp_done);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1; rst = 1'b1; mem_r_ena = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_bus_req", 64'(bus_req), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    rst = 1'b0;
    sbq.delete();
    bq.delete();
    mdl_rdata = '0;
    abort = 1'b0;
    run("after_rst_lh", 1, 0, 8'h03, 0, 64'h8000_0102, 64'h0, 1, 64'h0000_0000_8001_0000);

    for (int n = 0; n < 150; n++) begin
      nb   = 1 << $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      r    = (kind != 2);
      w    = (kind >= 2);
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'($urandom_range(0, 8 / nb - 1) * nb);
      ack  = w ? $urandom_range(1, TO) : $urandom_range(1, TO + 1);
      run("rand", r, w, be_of(nb), 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          ack, {$urandom, $urandom});
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("bus_drained", 64'(bq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
